coffee_purchase_sequencer: RTL

//  Initiator side of the coffee vending machine coin/buy protocol: on a start request, drives single-cycle

---
 rtl/coffee_vm_pkg.sv | 37 +++
 rtl/vm_cycle_counter.sv | 48 ++++
 rtl/coffee_purchase_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/coffee_vm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coffee_vm_pkg
// Purpose  : Shared types and constants for the coffee vending coin/buy
//            protocol: sequencer state encoding, purchase result codes,
//            default price and the coin-count clamp helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package coffee_vm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    COIN     = 3'd2,
    GAP      = 3'd3,
    BUY      = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_COFFEE  = 2'b01,
    RES_REFUND  = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_e;

  localparam int unsigned PRICE_COINS_DEFAULT = 3;

  // Never send more coins than the price: an extra coin voids the credit.
  function automatic logic [2:0] clamp_target(input logic [2:0] n, input logic [2:0] price);
    return (n > price) ? price : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module   : vm_cycle_counter
// Purpose  : Saturating up-counter with synchronous load and count enable.
//            tc is high while the count has reached limit; the count then
//            holds there instead of wrapping.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            load, load_val - synchronous load (has priority over en)
//            en             - count enable
//            limit          - terminal count value
//            tc             - terminal count reached
// Revision : 1.0 - initial release
// ============================================================================
module vm_cycle_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc = (count_q >= limit);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && !tc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coffee_purchase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : coffee_purchase_sequencer
// Purpose  : Initiator side of the vending coin/buy protocol. On an accepted
//            start it issues up to PRICE_COINS single-cycle coin pulses, then
//            one buy pulse, and classifies the vending FSM reply as coffee,
//            refund or timeout.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, n_coins      - purchase request and requested coin count
//            coffee_in           - vending FSM coffee output
//            machine_idle        - vending FSM return output (no credit held)
//            coin, buy           - one-cycle pulses to the vending FSM
//            busy, done          - purchase in progress / completion pulse
//            result, coins_sent  - outcome code and coins issued
// Revision : 1.0 - initial release
// ============================================================================
module coffee_purchase_sequencer
  import coffee_vm_pkg::*;
#(
  parameter int unsigned PRICE_COINS    = PRICE_COINS_DEFAULT,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] n_coins,
  input  logic       coffee_in,
  input  logic       machine_idle,
  output logic       coin,
  output logic       buy,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [2:0] coins_sent
);

  localparam logic [2:0] C_PRICE     = PRICE_COINS[2:0];
  // Counters count 0..limit, so a span of N cycles terminates at N-1.
  localparam logic [3:0] C_GAP_LIMIT = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [7:0] C_TO_LIMIT  = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] target_q, target_d;
  logic [2:0] coins_sent_q, coins_sent_d;
  logic [1:0] result_q, result_d;
  logic       buy_next_q, buy_next_d;  // after the gap: 1 = BUY, 0 = another COIN

  logic gap_load, gap_en, gap_tc;
  logic to_load, to_en, to_tc;
  logic full;

  assign full = (target_q == C_PRICE);

  vm_cycle_counter #(.WIDTH(4)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (4'd0),
    .en       (gap_en),
    .limit    (C_GAP_LIMIT),
    .tc       (gap_tc)
  );

  vm_cycle_counter #(.WIDTH(8)) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .load_val (8'd0),
    .en       (to_en),
    .limit    (C_TO_LIMIT),
    .tc       (to_tc)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    coins_sent_d = coins_sent_q;
    result_d     = result_q;
    buy_next_d   = buy_next_q;
    gap_load     = 1'b0;
    gap_en       = 1'b0;
    to_load      = 1'b0;
    to_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d     = clamp_target(n_coins, C_PRICE);
          coins_sent_d = 3'd0;
          result_d     = RES_NONE;
          state_d      = SYNC;
        end
      end
      SYNC: begin
        // Leftover credit from an aborted purchase blocks here until the
        // machine returns it; recovery belongs to the controller.
        if (target_q == 3'd0) begin
          result_d = RES_REFUND;
          state_d  = DONE;
        end else if (machine_idle) begin
          state_d = COIN;
        end
      end
      COIN: begin
        if (coins_sent_q < C_PRICE) begin
          coins_sent_d = coins_sent_q + 3'd1;
        end
        buy_next_d = !(({1'b0, coins_sent_q} + 4'd1) < {1'b0, target_q});
        gap_load   = 1'b1;
        if (GAP_CYCLES == 0) begin
          state_d = buy_next_d ? BUY : COIN;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        gap_en = 1'b1;
        if (gap_tc) begin
          state_d = buy_next_q ? BUY : COIN;
        end
      end
      BUY: begin
        to_load = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        to_en = 1'b1;
        // Acks are tested before the timeout so a same-cycle ack wins.
        if (full && coffee_in) begin
          result_d = RES_COFFEE;
          state_d  = DONE;
        end else if (!full && machine_idle) begin
          result_d = RES_REFUND;
          state_d  = DONE;
        end else if (to_tc) begin
          result_d = RES_TIMEOUT;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= 3'd0;
      coins_sent_q <= 3'd0;
      result_q     <= RES_NONE;
      buy_next_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      coins_sent_q <= coins_sent_d;
      result_q     <= result_d;
      buy_next_q   <= buy_next_d;
    end
  end

  // Moore decode: coin and buy come from distinct states, so never overlap.
  assign coin       = (state_q == COIN);
  assign buy        = (state_q == BUY);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign result     = result_q;
  assign coins_sent = coins_sent_q;

endmodule
`default_nettype wire
